// File: rtl/edac_dec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : edac_dec_pkg
// Description : Shared SECDED decode helpers: parity-width derivation, H-matrix
//               column generator and syndrome classification enum.
// Revision    : 1.0 - initial release
// ============================================================================
package edac_dec_pkg;

    typedef enum logic [1:0] {
        CLEAN     = 2'd0,
        CORR_DATA = 2'd1,
        CORR_PAR  = 2'd2,
        UNCORR    = 2'd3
    } syn_class_e;

    // Total parity width: Hamming bits r plus the overall-parity bit.
    function automatic int edac_d2p(input int dat_width);
        int r;
        r = 1;
        while ((1 << r) < dat_width + r + 1) r = r + 1;
        return r + 1;
    endfunction

    // j-th integer >= 3 that is not a power of two.
    function automatic int col(input int j);
        int n;
        int v;
        int res;
        n   = 0;
        v   = 3;
        res = 0;
        while (res == 0) begin
            if ((v & (v - 1)) != 0) begin
                if (n == j) res = v;
                n = n + 1;
            end
            v = v + 1;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/edac_syndrome_gen.sv
`default_nettype none
// ============================================================================
// Module      : edac_syndrome_gen
// Description : Combinational syndrome and overall-parity computation for a
//               {data, parity} SECDED codeword.
// Revision    : 1.0 - initial release
// ============================================================================
module edac_syndrome_gen
    import edac_dec_pkg::*;
#(
    parameter  int DAT_WIDTH = 8,
    localparam int PAR_WIDTH = edac_d2p(DAT_WIDTH),
    localparam int R_WIDTH   = PAR_WIDTH - 1,
    localparam int CW_WIDTH  = PAR_WIDTH + DAT_WIDTH
)(
    input  logic [CW_WIDTH-1:0] code,
    output logic [R_WIDTH-1:0]  syn,
    output logic                ov
);

    logic [R_WIDTH-1:0] w_hcol [DAT_WIDTH];

    for (genvar j = 0; j < DAT_WIDTH; j++) begin : g_col
        localparam int H = col(j);
        assign w_hcol[j] = H[R_WIDTH-1:0];
    end

    // Seeding with the received parity folds the final XOR into the sum.
    always_comb begin
        syn = code[R_WIDTH-1:0];
        for (int j = 0; j < DAT_WIDTH; j++) begin
            if (code[PAR_WIDTH+j]) syn = syn ^ w_hcol[j];
        end
    end

    assign ov = ^code;

endmodule
`default_nettype wire

// File: rtl/edac_secded_decoder.sv
`default_nettype none
// ============================================================================
// Module      : edac_secded_decoder
// Description : Two-stage SECDED read-side decoder with writeback request and
//               saturating error statistics. Writeback exists only when
//               COREEDAC_DEC_WRBK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module edac_secded_decoder
    import edac_dec_pkg::*;
#(
    parameter  int DAT_WIDTH  = 8,
    parameter  int ADDR_WIDTH = 8,
    parameter  int CNT_WIDTH  = 16,
    localparam int PAR_WIDTH  = edac_d2p(DAT_WIDTH),
    localparam int CW_WIDTH   = PAR_WIDTH + DAT_WIDTH
)(
    input  logic                  RCLK,
    input  logic                  NGRST,
    input  logic                  VALID_IN,
    input  logic [CW_WIDTH-1:0]   CODE_IN,
    input  logic [ADDR_WIDTH-1:0] ADDR_IN,
    output logic                  VALID_OUT,
    output logic [DAT_WIDTH-1:0]  DATA_OUT,
    output logic                  CORRECTABLE,
    output logic                  ERROR,
    output logic                  WRBK_REQ,
    input  logic                  WRBK_ACK,
    output logic [ADDR_WIDTH-1:0] WRBK_ADDR,
    output logic [CW_WIDTH-1:0]   WRBK_CODE,
    output logic                  WRBK_MISS,
    input  logic                  CLR_CNT,
    output logic [CNT_WIDTH-1:0]  CORR_CNT,
    output logic [CNT_WIDTH-1:0]  UNCORR_CNT,
    output logic [ADDR_WIDTH-1:0] ERR_ADDR,
    output logic                  ERR_ADDR_VLD
);

    localparam int R_WIDTH = PAR_WIDTH - 1;

    logic [R_WIDTH-1:0]    w_syn;
    logic                  w_ov;
    logic                  r_s1_vld;
    logic [R_WIDTH-1:0]    r_s1_syn;
    logic                  r_s1_ov;
    logic [CW_WIDTH-1:0]   r_s1_code;
    logic [ADDR_WIDTH-1:0] r_s1_addr;
    logic [DAT_WIDTH-1:0]  w_dhit;
    logic [CW_WIDTH-1:0]   w_flip;
    logic [CW_WIDTH-1:0]   w_fixed;
    syn_class_e            w_class;
    logic                  w_corr_evt;
    logic                  w_unc_evt;

    edac_syndrome_gen #(.DAT_WIDTH(DAT_WIDTH)) u_syn (
        .code (CODE_IN),
        .syn  (w_syn),
        .ov   (w_ov)
    );

    always_ff @(posedge RCLK or negedge NGRST) begin
        if (!NGRST) begin
            r_s1_vld  <= 1'b0;
            r_s1_syn  <= '0;
            r_s1_ov   <= 1'b0;
            r_s1_code <= '0;
            r_s1_addr <= '0;
        end else begin
            r_s1_vld  <= VALID_IN;
            r_s1_syn  <= w_syn;
            r_s1_ov   <= w_ov;
            r_s1_code <= CODE_IN;
            r_s1_addr <= ADDR_IN;
        end
    end

    for (genvar j = 0; j < DAT_WIDTH; j++) begin : g_match
        localparam int H = col(j);
        assign w_dhit[j] = (r_s1_syn == H[R_WIDTH-1:0]);
    end

    // Odd overall parity with an unmatched syndrome stays UNCORR and flips nothing.
    always_comb begin
        w_class = CLEAN;
        w_flip  = '0;
        if (r_s1_ov) begin
            w_class = UNCORR;
            if (r_s1_syn == '0) begin
                w_class              = CORR_PAR;
                w_flip[PAR_WIDTH-1]  = 1'b1;
            end
            for (int i = 0; i < R_WIDTH; i++) begin
                if (r_s1_syn == (R_WIDTH'(1) << i)) begin
                    w_class   = CORR_PAR;
                    w_flip[i] = 1'b1;
                end
            end
            for (int j = 0; j < DAT_WIDTH; j++) begin
                if (w_dhit[j]) begin
                    w_class              = CORR_DATA;
                    w_flip[PAR_WIDTH+j]  = 1'b1;
                end
            end
        end else if (r_s1_syn != '0) begin
            w_class = UNCORR;
        end
    end

    assign w_fixed    = r_s1_code ^ w_flip;
    assign w_corr_evt = r_s1_vld && ((w_class == CORR_DATA) || (w_class == CORR_PAR));
    assign w_unc_evt  = r_s1_vld && (w_class == UNCORR);

    always_ff @(posedge RCLK or negedge NGRST) begin
        if (!NGRST) begin
            VALID_OUT    <= 1'b0;
            DATA_OUT     <= '0;
            CORRECTABLE  <= 1'b0;
            ERROR        <= 1'b0;
            CORR_CNT     <= '0;
            UNCORR_CNT   <= '0;
            ERR_ADDR     <= '0;
            ERR_ADDR_VLD <= 1'b0;
        end else begin
            VALID_OUT   <= r_s1_vld;
            DATA_OUT    <= w_fixed[CW_WIDTH-1:PAR_WIDTH];
            CORRECTABLE <= w_corr_evt;
            ERROR       <= w_unc_evt;
            if (CLR_CNT) begin
                CORR_CNT     <= '0;
                UNCORR_CNT   <= '0;
                ERR_ADDR_VLD <= 1'b0;
            end else begin
                if (w_corr_evt && (CORR_CNT != '1))   CORR_CNT   <= CORR_CNT + 1'b1;
                if (w_unc_evt  && (UNCORR_CNT != '1)) UNCORR_CNT <= UNCORR_CNT + 1'b1;
                if (w_unc_evt) begin
                    ERR_ADDR     <= r_s1_addr;
                    ERR_ADDR_VLD <= 1'b1;
                end
            end
        end
    end

`ifdef COREEDAC_DEC_WRBK_EN
    // An ACK frees the slot in the same cycle, so a coincident correction loads.
    always_ff @(posedge RCLK or negedge NGRST) begin
        if (!NGRST) begin
            WRBK_REQ  <= 1'b0;
            WRBK_ADDR <= '0;
            WRBK_CODE <= '0;
            WRBK_MISS <= 1'b0;
        end else begin
            if (w_corr_evt && (!WRBK_REQ || WRBK_ACK)) begin
                WRBK_REQ  <= 1'b1;
                WRBK_ADDR <= r_s1_addr;
                WRBK_CODE <= w_fixed;
            end else if (WRBK_REQ && WRBK_ACK) begin
                WRBK_REQ  <= 1'b0;
            end
            if (CLR_CNT)
                WRBK_MISS <= 1'b0;
            else if (w_corr_evt && WRBK_REQ && !WRBK_ACK)
                WRBK_MISS <= 1'b1;
        end
    end
`else
    assign WRBK_REQ  = 1'b0;
    assign WRBK_ADDR = '0;
    assign WRBK_CODE = '0;
    assign WRBK_MISS = 1'b0;

    logic unused_wrbk;
    assign unused_wrbk = ^{WRBK_ACK, w_fixed[PAR_WIDTH-1:0]};
`endif

endmodule
`default_nettype wire
